multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle processor control unit.
// A single state register walks each instruction through IF/ID/EXE/MEM/WB.
// Every control output is a combinational decode of (state, opcode, zero).
module multicycle_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic       RegWre,
  output logic       RegDst,
  output logic [1:0] PCSrc,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  state_t r_state;
  state_t w_next;

  logic w_is_add, w_is_sub, w_is_addi, w_is_or, w_is_and, w_is_ori;
  logic w_is_slt, w_is_sw, w_is_lw, w_is_beq, w_is_j, w_is_halt;
  logic w_is_rtype, w_illegal;

  assign w_is_add  = (opcode == OP_ADD);
  assign w_is_sub  = (opcode == OP_SUB);
  assign w_is_addi = (opcode == OP_ADDI);
  assign w_is_or   = (opcode == OP_OR);
  assign w_is_and  = (opcode == OP_AND);
  assign w_is_ori  = (opcode == OP_ORI);
  assign w_is_slt  = (opcode == OP_SLT);
  assign w_is_sw   = (opcode == OP_SW);
  assign w_is_lw   = (opcode == OP_LW);
  assign w_is_beq  = (opcode == OP_BEQ);
  assign w_is_j    = (opcode == OP_J);
  assign w_is_halt = (opcode == OP_HALT);

  assign w_is_rtype = w_is_add | w_is_sub | w_is_or | w_is_and | w_is_slt;
  assign w_illegal  = ~(w_is_rtype | w_is_addi | w_is_ori | w_is_sw | w_is_lw |
                        w_is_beq | w_is_j | w_is_halt);

  assign state = r_state;

  // State register; a low reset at any edge returns the FSM to instruction fetch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection from the current state and the decoded opcode.
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF: begin
        w_next = S_ID;
      end
      S_ID: begin
        if (w_is_j || w_illegal) begin
          w_next = S_IF;
        end else if (w_is_halt) begin
          w_next = S_HALT;
        end else begin
          w_next = S_EXE;
        end
      end
      S_EXE: begin
        if (w_is_beq) begin
          w_next = S_IF;
        end else if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (w_is_lw) begin
          w_next = S_WB;
        end else begin
          w_next = S_IF;
        end
      end
      S_WB: begin
        w_next = S_IF;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IF;
      end
    endcase
  end

  // Control decode: enables depend on state, datapath selects on opcode alone.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    RegWre    = 1'b0;
    ALUSrcB   = w_is_addi | w_is_ori | w_is_lw | w_is_sw;
    ExtSel    = ~w_is_ori;
    DBDataSrc = w_is_lw;
    RegDst    = w_is_rtype;
    PCSrc     = 2'b00;

    if (w_is_sub || w_is_beq) begin
      ALUOp = ALU_SUB;
    end else if (w_is_or || w_is_ori) begin
      ALUOp = ALU_OR;
    end else if (w_is_and) begin
      ALUOp = ALU_AND;
    end else if (w_is_slt) begin
      ALUOp = ALU_SLT;
    end else begin
      ALUOp = ALU_ADD;
    end

    case (r_state)
      S_IF: begin
        IRWre = 1'b1;
      end
      S_ID: begin
        PCWre = w_is_j | w_illegal;
      end
      S_EXE: begin
        PCWre = w_is_beq;
      end
      S_MEM: begin
        PCWre = w_is_sw;
        mRD   = w_is_lw;
        mWR   = w_is_sw;
      end
      S_WB: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      S_HALT: begin
        PCWre = 1'b0;
      end
      default: begin
        PCWre = 1'b0;
      end
    endcase

    // The next-PC select is held at PC+4 while fetching or halted.
    if ((r_state == S_IF) || (r_state == S_HALT)) begin
      PCSrc = 2'b00;
    end else if (w_is_j) begin
      PCSrc = 2'b10;
    end else if (w_is_beq && zero) begin
      PCSrc = 2'b01;
    end else begin
      PCSrc = 2'b00;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit against an instruction-level model.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       PCWre, IRWre, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc, RegWre, RegDst;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
  localparam logic [5:0] OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010;
  localparam logic [5:0] SLT = 6'b100110, SW = 6'b110000, LW = 6'b110001;
  localparam logic [5:0] BEQ = 6'b110100, J = 6'b111000, HALT = 6'b111111;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc),
    .RegWre(RegWre), .RegDst(RegDst), .PCSrc(PCSrc), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [2:0] st, input logic pcw, input logic irw,
                                       input logic asb, input logic ext, input logic [2:0] aop,
                                       input logic rd, input logic wr, input logic dbs,
                                       input logic rw, input logic rdst, input logic [1:0] pcs);
    return {15'd0, st, pcw, irw, asb, ext, aop, rd, wr, dbs, rw, rdst, pcs};
  endfunction

  function automatic bit is_rtype(input logic [5:0] op);
    return op == ADD || op == SUB || op == OR_ || op == AND_ || op == SLT;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return is_rtype(op) || op == ADDI || op == ORI || op == SW || op == LW ||
           op == BEQ || op == J || op == HALT;
  endfunction

  // Cycles an instruction occupies (halt: cycles before the halted state).
  function automatic int latency(input logic [5:0] op);
    if (op == J || !is_legal(op)) return 2;
    if (op == BEQ) return 3;
    if (op == LW) return 5;
    if (op == HALT) return 2;
    return 4;
  endfunction

  // State the instruction occupies in its k-th cycle.
  function automatic logic [2:0] state_at(input logic [5:0] op, input int k);
    if (k == 0) return 3'd0;
    if (k == 1) return 3'd1;
    if (op == HALT) return 3'd5;
    if (k == 2) return 3'd2;
    if (k == 3) return (op == LW || op == SW) ? 3'd3 : 3'd4;
    return 3'd4;
  endfunction

  function automatic logic [31:0] expect_out(input logic [5:0] op, input int k, input logic z);
    logic [2:0] st;
    logic [2:0] aop;
    logic [1:0] pcs;
    logic       pcw;
    st  = state_at(op, k);
    pcw = (op != HALT) && (k == latency(op) - 1);
    if (op == SUB || op == BEQ) aop = 3'b001;
    else if (op == OR_ || op == ORI) aop = 3'b011;
    else if (op == AND_) aop = 3'b100;
    else if (op == SLT) aop = 3'b110;
    else aop = 3'b000;
    if (st == 3'd0 || st == 3'd5) pcs = 2'b00;
    else if (op == J) pcs = 2'b10;
    else if (op == BEQ && z) pcs = 2'b01;
    else pcs = 2'b00;
    return pack(st, pcw, k == 0,
                op == ADDI || op == ORI || op == LW || op == SW,
                op != ORI, aop,
                st == 3'd3 && op == LW, st == 3'd3 && op == SW,
                op == LW, st == 3'd4, is_rtype(op), pcs);
  endfunction

  // Run one instruction from its IF cycle. zsel 0/1 forces zero, 2 randomizes it.
  // rst_at >= 0 drives reset low during that cycle so the following edge aborts.
  task automatic run_instr(input logic [5:0] op, input int zsel, input int rst_at, input int n_halt);
    int total;
    int ra;
    total = (op == HALT) ? 2 + n_halt : latency(op);
    ra = (op == HALT) ? total - 1 : rst_at;
    opcode = op;
    for (int k = 0; k < total; k++) begin
      zero = (zsel == 2) ? 1'($urandom_range(1, 0)) : 1'(zsel);
      if (k == ra) reset = 1'b0;
      @(negedge clk);
      check_val($sformatf("op%02h_k%0d", op, k),
                pack(state, PCWre, IRWre, ALUSrcB, ExtSel, ALUOp, mRD, mWR,
                     DBDataSrc, RegWre, RegDst, PCSrc),
                expect_out(op, k, zero));
      @(posedge clk);
      #1;
      if (k == ra) begin
        reset = 1'b1;
        break;
      end
    end
  endtask

  logic [5:0] rop;
  int         rlat;
  int         rrst;

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_val("reset_if", pack(state, PCWre, IRWre, 1'b0, 1'b0, 3'd0, mRD, mWR, 1'b0,
                               RegWre, 1'b0, PCSrc),
              pack(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    @(posedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(ADD, 2, -1, 0);
    run_instr(LW, 2, -1, 0);
    run_instr(BEQ, 1, -1, 0);
    run_instr(BEQ, 0, -1, 0);
    run_instr(J, 2, -1, 0);
    run_instr(6'b101010, 2, -1, 0);
    run_instr(HALT, 2, -1, 20);
    run_instr(SW, 2, 3, 0);
    run_instr(ORI, 2, -1, 0);
    run_instr(SW, 2, -1, 0);
    run_instr(LW, 2, 2, 0);
    run_instr(ADDI, 2, -1, 0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(13, 0))
        0: rop = ADD;   1: rop = SUB;   2: rop = ADDI;  3: rop = OR_;
        4: rop = AND_;  5: rop = ORI;   6: rop = SLT;   7: rop = SW;
        8: rop = LW;    9: rop = BEQ;   10: rop = J;    11: rop = HALT;
        default: rop = 6'($urandom_range(63, 0));
      endcase
      rlat = latency(rop);
      rrst = ($urandom_range(7, 0) == 0) ? int'($urandom_range(rlat - 1, 0)) : -1;
      run_instr(rop, 2, rrst, int'($urandom_range(5, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
